// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) and three-step register-register
// ALU execute (T3-T5). All strobes are decoded from the registered state and IR.

// One register slot: raises its bus-drive or load enable when selected.
module control_sequencer_lane #(
    parameter int IDX   = 0,
    parameter int SEL_W = 4
) (
    input  logic             drive_en,
    input  logic [SEL_W-1:0] drive_sel,
    input  logic             load_en,
    input  logic [SEL_W-1:0] load_sel,
    output logic             rout,
    output logic             rin
);
    assign rout = drive_en && (drive_sel == SEL_W'(IDX));
    assign rin  = load_en  && (load_sel  == SEL_W'(IDX));
endmodule

module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int NUM_OPS  = 12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        MDRRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [11:0] ALUControl,
    output logic        instr_done,
    output logic        illegal,
    output logic [2:0]  step
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6
    } state_t;

    state_t state, state_nxt;
    logic   t1_first;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       legal;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign legal     = (op < 5'(NUM_OPS));
    assign unused_ir = ^IR[14:0];

    // t1_first is high only in the cycle right after T0, so a stalled fetch
    // still increments the PC exactly once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            t1_first <= 1'b0;
        end else begin
            state    <= state_nxt;
            t1_first <= (state == T0);
        end
    end

    always_comb begin
        state_nxt  = state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        MDRRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            IDLE: if (run) state_nxt = T0;
            T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = t1_first;
                MDRRead = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_nxt = T2;
            end
            T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (legal) begin
                    Yin       = 1'b1;
                    state_nxt = T4;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = run ? T0 : IDLE;
                end
            end
            T4: begin
                Zin       = 1'b1;
                state_nxt = T5;
            end
            T5: begin
                Zlowout    = 1'b1;
                instr_done = 1'b1;
                state_nxt  = run ? T0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register enables: Rb in T3, Rc in T4, Ra write-back in T5.
    logic                 drive_en, load_en;
    logic [3:0]           drive_sel;
    logic [NUM_REGS-1:0]  rout_vec, rin_vec;

    assign drive_en  = ((state == T3) && legal) || (state == T4);
    assign drive_sel = (state == T4) ? rc : rb;
    assign load_en   = (state == T5);

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
            control_sequencer_lane #(.IDX(g), .SEL_W(4)) u_lane (
                .drive_en  (drive_en),
                .drive_sel (drive_sel),
                .load_en   (load_en),
                .load_sel  (ra),
                .rout      (rout_vec[g]),
                .rin       (rin_vec[g])
            );
        end
    endgenerate

    assign Rout       = rout_vec;
    assign Rin        = rin_vec;
    assign ALUControl = (state == T4) ? (12'd1 << op) : 12'd0;
    assign step       = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized checks of control_sequencer against a per-cycle
// expected-trace model built from the instruction's fields and wait count.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRRead, MDRin, MDRout, IRin, Yin;
    logic [15:0] Rout, Rin;
    logic [11:0] ALUControl;
    logic        instr_done, illegal;
    logic [2:0]  step;

    int tests = 0;
    int fails = 0;

    // strobe order: PCout MARin IncPC Zin Zlowout PCin MDRRead MDRin MDRout IRin Yin
    localparam logic [10:0] S_PCOUT = 11'h400, S_MARIN = 11'h200, S_INCPC = 11'h100;
    localparam logic [10:0] S_ZIN   = 11'h080, S_ZLOW  = 11'h040, S_PCIN  = 11'h020;
    localparam logic [10:0] S_MDRRD = 11'h010, S_MDRIN = 11'h008, S_MDROUT = 11'h004;
    localparam logic [10:0] S_IRIN  = 11'h002, S_YIN   = 11'h001;

    logic [59:0] exp_q[$];

    control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .PCin(PCin), .MDRRead(MDRRead), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Rout(Rout), .Rin(Rin), .ALUControl(ALUControl),
        .instr_done(instr_done), .illegal(illegal), .step(step)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] obs();
        return {step, PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRRead, MDRin,
                MDRout, IRin, Yin, Rout, Rin, ALUControl, instr_done, illegal};
    endfunction

    function automatic logic [59:0] mk(input int st, input logic [10:0] s,
                                       input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [11:0] alu, input logic dn, input logic il);
        return {3'(st), s, ro, ri, alu, dn, il};
    endfunction

    task automatic check(input string tag, input logic [59:0] expv);
        logic [59:0] o;
        o = obs();
        tests++;
        assert (o === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, expv);
        end
    endtask

    // Expected outputs, one entry per cycle from T0 to the instruction's last cycle.
    task automatic build(input logic [31:0] ir, input int waits);
        int op, ra, rb, rc;
        op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        exp_q.delete();
        exp_q.push_back(mk(1, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(2, S_ZLOW | S_PCIN | S_MDRRD | S_MDRIN, 0, 0, 0, 0, 0));
        for (int w = 0; w < waits; w++)
            exp_q.push_back(mk(2, S_ZLOW | S_MDRRD | S_MDRIN, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(3, S_MDROUT | S_IRIN, 0, 0, 0, 0, 0));
        if (op >= 12) begin
            exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 1));
        end else begin
            exp_q.push_back(mk(4, S_YIN, 16'(1) << rb, 0, 0, 0, 0));
            exp_q.push_back(mk(5, S_ZIN, 16'(1) << rc, 0, 12'(1) << op, 0, 0));
            exp_q.push_back(mk(6, S_ZLOW, 0, 16'(1) << ra, 0, 1, 0));
        end
    endtask

    // Entered just after the edge into T0; leaves at the negedge of the last cycle.
    task automatic exec(input string tag, input logic [31:0] ir, input int waits,
                        input int drop_at, input int abort_at);
        build(ir, waits);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), exp_q[i]);
            if (i == abort_at) begin
                #1 clr = 1'b1;
                #1 check($sformatf("%s_async_clr", tag), 60'h0);
                @(posedge clk);
                #1 check($sformatf("%s_clr_hold", tag), 60'h0);
                @(negedge clk);
                clr = 1'b0;
                run = 1'b1;
                check($sformatf("%s_clr_idle", tag), 60'h0);
                return;
            end
            run       = (i >= drop_at) ? 1'b0 : 1'b1;
            mem_ready = (i == 1 + waits) ? 1'b1 :
                        (i >= 1 && i <= waits) ? 1'b0 : 1'($urandom);
            IR        = (i >= 2 + waits) ? ir : $urandom;
        end
    endtask

    task automatic idle_then_restart(input string tag);
        @(negedge clk);
        check(tag, 60'h0);
        run = 1'b1;
    endtask

    initial begin
        clr = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = 32'h0;
        #12 check("reset", 60'h0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_hold[%0d]", i), 60'h0);
            mem_ready = 1'($urandom);
            IR        = $urandom;
        end
        run = 1'b1;

        exec("or_basic", 32'h4A920000, 0, 1000, -1);
        exec("mem_wait", 32'h4A920000, 3, 1000, -1);
        exec("illegal",  32'h60000000, 0, 1000, -1);
        exec("alias",    32'h29998000, 0, 1000, -1);
        exec("run_drop", 32'h4A920000, 1, 3, -1);
        idle_then_restart("run_drop_idle");
        exec("clr_t4",   32'h4A920000, 0, 1000, 4);
        exec("restart",  32'h4A920000, 0, 1000, -1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ir;
            int waits, drop;
            ir    = $urandom;
            waits = int'($urandom_range(0, 4));
            drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 + waits)) : 1000;
            exec($sformatf("rand%0d", n), ir, waits, drop, -1);
            if (drop != 1000) idle_then_restart($sformatf("rand%0d_idle", n));
        end

        @(negedge clk);
        check("final_t0", mk(1, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The module SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have port run, input, 1 bit: when high, instructions are fetched and executed continuously.
REQ-004 The module SHALL have port mem_ready, input, 1 bit: memory read data is valid on Mdatain this cycle.
REQ-005 The module SHALL have port IR, input, 32 bits: instruction register contents from the datapath.
REQ-006 The module SHALL have outputs PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRRead, MDRin, MDRout, IRin and Yin, 1 bit each: the datapath strobes of the same names.
REQ-007 The module SHALL have port Rout, output, 16 bits: one-hot general-register bus-drive enables, bit n = Rn out.
REQ-008 The module SHALL have port Rin, output, 16 bits: one-hot general-register load enables, bit n = Rn in.
REQ-009 The module SHALL have port ALUControl, output, 12 bits: one-hot ALU operation select.
REQ-010 The module SHALL have port instr_done, output, 1 bit: one-cycle pulse on completion of an instruction.
REQ-011 The module SHALL have port illegal, output, 1 bit: one-cycle pulse when an unsupported opcode is decoded.
REQ-012 The module SHALL have port step, output, 3 bits: current state encoding, for debug.

Function
REQ-013 The module SHALL implement states IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5 and T5=6, presented on step.
REQ-014 All outputs SHALL be Moore outputs decoded from the registered state and IR only, with no combinational path from run or mem_ready.
REQ-015 IDLE SHALL drive all strobes low and SHALL move to T0 when run=1.
REQ-016 T0 SHALL assert PCout, MARin, IncPC and Zin, then move to T1 unconditionally.
REQ-017 T1 SHALL assert Zlowout, PCin, MDRRead and MDRin.
REQ-018 T1 SHALL hold while mem_ready=0 and move to T2 when mem_ready=1.
REQ-019 PCin SHALL be asserted only in the first cycle of T1, so that the PC increments exactly once per fetch regardless of wait cycles.
REQ-020 T2 SHALL assert MDRout and IRin, then move to T3.
REQ-021 Field decode SHALL use the IR value present in T3 and later: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-022 In T3, if op<=11, the module SHALL assert Rout[Rb] and Yin, then move to T4.
REQ-023 In T3, if op>=12, the module SHALL pulse illegal, assert no strobes, and go to T0 if run=1, else IDLE.
REQ-024 T4 SHALL assert Rout[Rc], Zin and ALUControl=1<<op, then move to T5.
REQ-025 ALUControl SHALL be zero in every state other than T4.
REQ-026 T5 SHALL assert Zlowout and Rin[Ra] and pulse instr_done, then go to T0 if run=1, else IDLE.
REQ-027 Deassertion of run mid-instruction SHALL NOT abort the instruction; the sequencer SHALL stop only at an instruction boundary (T5 exit or illegal exit).
REQ-028 At most one bit of Rout and at most one bit of Rin SHALL be high in any cycle.
REQ-029 Rout and Rin SHALL never be high in the same cycle.
REQ-030 Rb=Rc SHALL be legal, with the register driven in both T3 and T4.
REQ-031 Ra equal to Rb or Rc SHALL be legal, with the write occurring in T5 only.

Reset
REQ-032 Assertion of clr SHALL immediately force state IDLE, independent of clk.
REQ-033 Assertion of clr SHALL immediately drive all outputs to 0, including Rout=16'h0000, Rin=16'h0000, ALUControl=12'h000 and step=0.
REQ-034 Reset during any state, including the T1 wait, SHALL abandon the instruction with no further strobes.
REQ-035 After clr deasserts, the first possible transition SHALL be IDLE->T0 on a rising clk with run=1.

Verification
REQ-036 The bench SHALL cover basic OR execution: IR=32'h4A920000, run=1, mem_ready=1 -> T3 Rout=16'h0004 with Yin; T4 Rout=16'h0010, ALUControl=12'h200, Zin; T5 Rin=16'h0020, Zlowout, instr_done; 6 clocks from T0 to T5 exit.
REQ-037 The bench SHALL cover the memory wait: mem_ready=0 for 3 cycles in T1 -> step stays 2 for 4 cycles, PCin high only in the first cycle, MDRRead/MDRin high throughout, then T2.
REQ-038 The bench SHALL cover the illegal opcode: IR=32'h60000000 (op=12) -> illegal pulses in T3, no Rout, Yin or Zin, next state T0.
REQ-039 The bench SHALL cover run dropped in T2: the instruction completes through T5, instr_done pulses, and the sequencer enters IDLE with all strobes low.
REQ-040 The bench SHALL cover asynchronous reset in T4: clr raised mid-cycle -> Zin, ALUControl and Rout go to 0 before the next clk edge, step=0, and the restart fetch begins at T0.
REQ-041 The bench SHALL cover register aliasing: IR with Ra=Rb=Rc=3 and op=5 -> Rout=16'h0008 in T3 and T4, Rin=16'h0008 in T5, ALUControl=12'h020.
